// File: rtl/chaos_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : chaos_pkg
//  Brief    : Shared types, widths and key packing helper for the Chaos_Key
//             sequencer and its phase timer.
//  Revision : 1.0 - initial release
// ============================================================================
package chaos_pkg;

    localparam int KEY_W  = 32;
    localparam int CODE_W = 8;

    // Sequencer states; encoding fixed so waveforms read the same across builds
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CRST    = 3'd1,
        ST_WARM_HI = 3'd2,
        ST_WARM_LO = 3'd3,
        ST_STEP_HI = 3'd4,
        ST_STEP_LO = 3'd5,
        ST_OUT     = 3'd6
    } state_t;

    // Key word layout seen by software: W in the top byte, X in the bottom byte
    function automatic logic [KEY_W-1:0] pack_key(
        input logic [CODE_W-1:0] x,
        input logic [CODE_W-1:0] y,
        input logic [CODE_W-1:0] z,
        input logic [CODE_W-1:0] w
    );
        return {w, z, y, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/chaos_hs_timer.sv
`default_nettype none
// ============================================================================
//  Module   : chaos_hs_timer
//  Brief    : Handshake phase watchdog. Cleared on every phase entry, counts
//             cycles spent in the phase and flags expiry on the TIMEOUT_CYC-th
//             cycle. Saturates so a long stay never wraps back to "fresh".
//  Revision : 1.0 - initial release
// ============================================================================
module chaos_hs_timer #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_expired
);

    localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Cycle counter: zero on the first cycle of a phase, holds at the limit
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt != c_last) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    assign o_expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/chaos_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : chaos_key_sequencer
//  Brief    : Runs a Chaos_Key job in hardware: core reset, warm-up steps,
//             then one four-phase STEP/DONE handshake per delivered key word
//             on a valid/ready stream. All outputs are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module chaos_key_sequencer
    import chaos_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int WARMUP_STEPS = 64,
    parameter int CRST_CYCLES  = 2,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_shift,
    input  logic [CNT_W-1:0]  req_count,
    input  logic              abort,
    output logic              CHAOS_RESET,
    output logic              CHAOS_STEP,
    output logic [31:0]       CHAOS_SHIFT,
    input  logic              CHAOS_DONE,
    input  logic [CODE_W-1:0] CHAOS_CODE_X,
    input  logic [CODE_W-1:0] CHAOS_CODE_Y,
    input  logic [CODE_W-1:0] CHAOS_CODE_Z,
    input  logic [CODE_W-1:0] CHAOS_CODE_W,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [KEY_W-1:0]  key_data,
    output logic              key_last,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] c_crst_last = CNT_W'(CRST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_warm_last = CNT_W'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);
    localparam bit               c_has_warm  = (WARMUP_STEPS > 0);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] r_warm_cnt;
    logic [CNT_W-1:0] r_crst_cnt;

    logic w_accept;
    logic w_xfer;
    logic w_word_last;
    logic w_expired;
    logic w_timeout;
    logic w_capture;

    logic w_req_ready_nxt;
    logic w_busy_nxt;
    logic w_crst_nxt;
    logic w_step_nxt;
    logic w_key_valid_nxt;
    logic w_key_last_nxt;

    assign w_accept    = (r_state == ST_IDLE) && req_valid && req_ready;
    assign w_xfer      = (r_state == ST_OUT) && key_ready;
    assign w_word_last = (r_word_cnt == (r_count - CNT_W'(1)));
    assign w_capture   = (r_state == ST_STEP_HI) && (w_state_nxt == ST_STEP_LO);

    // Any state change restarts the watchdog, so each HI/LO phase gets a full budget
    chaos_hs_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_hs_timer (
        .clk       (CLK),
        .rst       (RESET),
        .i_clear   (w_state_nxt != r_state),
        .o_expired (w_expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything, including a timeout or a key transfer
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (req_count != '0)) w_state_nxt = ST_CRST;
            end
            ST_CRST: begin
                if (r_crst_cnt == c_crst_last) w_state_nxt = c_has_warm ? ST_WARM_HI : ST_STEP_HI;
            end
            ST_WARM_HI: begin
                if (CHAOS_DONE) begin
                    w_state_nxt = ST_WARM_LO;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_WARM_LO: begin
                if (!CHAOS_DONE) begin
                    w_state_nxt = (r_warm_cnt == c_warm_last) ? ST_STEP_HI : ST_WARM_HI;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_STEP_HI: begin
                if (CHAOS_DONE) begin
                    w_state_nxt = ST_STEP_LO;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_STEP_LO: begin
                if (!CHAOS_DONE) begin
                    w_state_nxt = ST_OUT;
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            ST_OUT: begin
                if (key_ready) w_state_nxt = w_word_last ? ST_IDLE : ST_STEP_HI;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_timeout   = 1'b0;
        end
    end

    // Output decode from the next state so the registered outputs line up with r_state
    always_comb begin
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_crst_nxt      = (w_state_nxt == ST_CRST);
        w_step_nxt      = (w_state_nxt == ST_WARM_HI) || (w_state_nxt == ST_STEP_HI);
        w_key_valid_nxt = (w_state_nxt == ST_OUT);
        w_key_last_nxt  = (w_state_nxt == ST_OUT) && w_word_last;
    end

    // Output registers; key_data is only loaded on a STEP handshake so it holds through OUT
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_ready   <= 1'b0;
            busy        <= 1'b0;
            CHAOS_RESET <= 1'b0;
            CHAOS_STEP  <= 1'b0;
            CHAOS_SHIFT <= '0;
            key_valid   <= 1'b0;
            key_last    <= 1'b0;
            key_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            req_ready   <= w_req_ready_nxt;
            busy        <= w_busy_nxt;
            CHAOS_RESET <= w_crst_nxt;
            CHAOS_STEP  <= w_step_nxt;
            key_valid   <= w_key_valid_nxt;
            key_last    <= w_key_last_nxt;
            if (w_accept) begin
                CHAOS_SHIFT <= req_shift;
            end
            if (w_capture) begin
                key_data <= pack_key(CHAOS_CODE_X, CHAOS_CODE_Y, CHAOS_CODE_Z, CHAOS_CODE_W);
            end
            if (w_accept) begin
                timeout_err <= 1'b0;
            end else if (w_timeout) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Job bookkeeping: requested count, delivered words, warm-up steps, core-reset length
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count    <= '0;
            r_word_cnt <= '0;
            r_warm_cnt <= '0;
            r_crst_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_count    <= req_count;
                r_word_cnt <= '0;
                r_warm_cnt <= '0;
            end else begin
                if (w_xfer) r_word_cnt <= r_word_cnt + CNT_W'(1);
                if ((r_state == ST_WARM_LO) && !CHAOS_DONE) r_warm_cnt <= r_warm_cnt + CNT_W'(1);
            end
            r_crst_cnt <= (r_state == ST_CRST) ? (r_crst_cnt + CNT_W'(1)) : '0;
        end
    end

endmodule
`default_nettype wire
